// File: rtl/ahb_uart_pkg.sv
// ahb_uart_pkg: register map, STATUS/CTRL bit indices, HTRANS encodings and TX FSM states for ahb_uart_slave
package ahb_uart_pkg;
  localparam int OFF_DATA = 'h0;
  localparam int OFF_STATUS = 'h4;
  localparam int OFF_CTRL = 'h8;
  localparam int ST_TX_FULL = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_RX_OVR = 4;
  localparam int ST_TX_DROP = 5;
  localparam int CTRL_RX_IE = 0;
  localparam int CTRL_TX_IE = 1;
  typedef enum logic [1:0] {HT_IDLE, HT_BUSY, HT_NONSEQ, HT_SEQ} htrans_e;
  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_BUSY, TX_DRAIN} tx_state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: WIDTH x DEPTH FIFO (push/din in, combinational head dout, full/empty out); push while full is accepted only with a same-cycle pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wptr, rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic do_push, do_pop;
  assign empty = wptr == rptr;
  assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign dout = mem[rptr[AW-1:0]];
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wptr[AW-1:0]] <= din;
endmodule

// File: rtl/ahb_uart_slave.sv
// ahb_uart_slave: zero-wait AHB-lite slave (HSEL/HADDR/HTRANS/HWRITE/HWDATA in, HRDATA out) feeding uart_in/uart_in_valid from a TX FIFO and filling an RX FIFO from uart_out/uart_out_valid, with sticky errors and irq
module ahb_uart_slave
  import ahb_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [7:0]        uart_in,
  output logic              uart_in_valid,
  input  logic              tx_ready,
  input  logic [7:0]        uart_out,
  input  logic              uart_out_valid,
  output logic              irq
);
  localparam logic [ADDR_W-3:0] A_DATA = (ADDR_W-2)'(OFF_DATA >> 2);
  localparam logic [ADDR_W-3:0] A_STATUS = (ADDR_W-2)'(OFF_STATUS >> 2);
  localparam logic [ADDR_W-3:0] A_CTRL = (ADDR_W-2)'(OFF_CTRL >> 2);
  tx_state_e state;
  logic dp_valid, dp_write, capture;
  logic [ADDR_W-3:0] dp_addr;
  logic wr_data, wr_status, wr_ctrl, rd, rd_data;
  logic tx_full, tx_empty, tx_pop, rx_full, rx_empty, rx_pop;
  logic [7:0] tx_head, rx_head;
  logic rx_ovr, tx_drop;
  logic [1:0] ctrl;
  logic [5:0] status;
  logic unused_bits;
  assign HREADYOUT = 1'b1;
  assign HRESP = 1'b0;
  assign unused_bits = ^{HSIZE, HADDR[1:0], HWDATA[31:8]};
  assign capture = HSEL & HTRANS[1] & HREADY;
  assign rd = dp_valid & ~dp_write;
  assign rd_data = rd & (dp_addr == A_DATA);
  assign wr_data = dp_valid & dp_write & (dp_addr == A_DATA);
  assign wr_status = dp_valid & dp_write & (dp_addr == A_STATUS);
  assign wr_ctrl = dp_valid & dp_write & (dp_addr == A_CTRL);
  assign tx_pop = state == TX_SEND;
  assign rx_pop = rd_data & ~rx_empty;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk, .n_rst, .push(wr_data), .pop(tx_pop), .din(HWDATA[7:0]),
    .dout(tx_head), .full(tx_full), .empty(tx_empty)
  );
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk, .n_rst, .push(uart_out_valid), .pop(rx_pop), .din(uart_out),
    .dout(rx_head), .full(rx_full), .empty(rx_empty)
  );
  always_comb begin
    status = '0;
    status[ST_TX_FULL] = tx_full;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_RX_FULL] = rx_full;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_RX_OVR] = rx_ovr;
    status[ST_TX_DROP] = tx_drop;
  end
  always_comb
    HRDATA = !rd ? '0 :
             dp_addr == A_DATA ? {24'h0, rx_empty ? 8'h00 : rx_head} :
             dp_addr == A_STATUS ? {26'h0, status} :
             dp_addr == A_CTRL ? {30'h0, ctrl} : '0;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr <= '0;
    end else begin
      dp_valid <= capture;
      if (capture) begin
        dp_write <= HWRITE;
        dp_addr <= HADDR[ADDR_W-1:2];
      end
    end
  // Sticky bits: a same-cycle set beats the write-1-to-clear
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      rx_ovr <= 1'b0;
      tx_drop <= 1'b0;
      ctrl <= '0;
      irq <= 1'b0;
    end else begin
      rx_ovr <= (uart_out_valid & rx_full & ~rx_pop) | (rx_ovr & ~(wr_status & HWDATA[ST_RX_OVR]));
      tx_drop <= (wr_data & tx_full & ~tx_pop) | (tx_drop & ~(wr_status & HWDATA[ST_TX_DROP]));
      ctrl <= wr_ctrl ? HWDATA[1:0] : ctrl;
      irq <= (ctrl[CTRL_RX_IE] & ~rx_empty) | (ctrl[CTRL_TX_IE] & tx_empty);
    end
  // One strobe per byte, then wait for the UART to go busy and idle again
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state <= TX_IDLE;
      uart_in_valid <= 1'b0;
      uart_in <= 8'h00;
    end else begin
      case (state)
        TX_IDLE:
          if (!tx_empty && tx_ready) begin
            state <= TX_SEND;
            uart_in_valid <= 1'b1;
            uart_in <= tx_head;
          end
        TX_SEND: begin
          state <= TX_BUSY;
          uart_in_valid <= 1'b0;
        end
        TX_BUSY: if (!tx_ready) state <= TX_DRAIN;
        TX_DRAIN: if (tx_ready) state <= TX_IDLE;
        default: state <= TX_IDLE;
      endcase
    end
endmodule

// File: tb/tb_ahb_uart_slave.sv
// tb_ahb_uart_slave: scoreboard bench for ahb_uart_slave with a queue-based FIFO/UART reference model
module tb_ahb_uart_slave;
  import ahb_uart_pkg::*;
  localparam int D = 16;
  logic clk = 0, n_rst = 0;
  logic HSEL = 0, HWRITE = 0, HREADY = 1;
  logic [3:0] HADDR = 0;
  logic [1:0] HTRANS = 0;
  logic [2:0] HSIZE = 0;
  logic [31:0] HWDATA = 0;
  logic [31:0] HRDATA;
  logic HREADYOUT, HRESP, uart_in_valid, irq, tx_ready, uart_out_valid;
  logic [7:0] uart_in, uart_out;
  logic loop_en = 0, lb_ready = 1, lb_valid = 0, lb_busy = 0;
  logic man_ready = 1, man_valid = 0, rd_dp = 0;
  logic [7:0] lb_byte = 0, man_byte = 0, lb_b;
  logic m_ovr = 0, m_drop = 0;
  logic [1:0] m_ctrl = 0;
  logic [7:0] tx_m[$], rx_m[$];
  logic [31:0] rd_exp[$];
  string rd_nm[$];
  int checks = 0, errors = 0;
  assign tx_ready = loop_en ? lb_ready : man_ready;
  assign uart_out_valid = loop_en ? lb_valid : man_valid;
  assign uart_out = loop_en ? lb_byte : man_byte;
  ahb_uart_slave #(.FIFO_DEPTH(D), .ADDR_W(4)) dut (
    .clk(clk), .n_rst(n_rst), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP), .uart_in(uart_in), .uart_in_valid(uart_in_valid), .tx_ready(tx_ready),
    .uart_out(uart_out), .uart_out_valid(uart_out_valid), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] st_model();
    return {26'h0, m_drop, m_ovr, rx_m.size() == 0, rx_m.size() == D, tx_m.size() == 0, tx_m.size() == D};
  endfunction
  function automatic void rx_push(input logic [7:0] b);
    if (rx_m.size() < D) rx_m.push_back(b);
    else m_ovr = 1;
  endfunction
  always @(negedge clk) begin
    if (rd_dp) begin
      if (rd_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_scoreboard: got %h with no expected read", HRDATA);
      end else chk(rd_nm.pop_front(), HRDATA, rd_exp.pop_front());
    end
    if (uart_in_valid) begin
      if (tx_m.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected: got uart_in %h with no expected byte", uart_in);
      end else chk("uart_in", {24'h0, uart_in}, {24'h0, tx_m.pop_front()});
    end
  end
  initial forever begin
    @(negedge clk);
    if (loop_en && uart_in_valid) begin
      lb_busy = 1;
      lb_b = uart_in;
      lb_ready = 0;
      repeat (2 + $urandom_range(0, 3)) @(negedge clk);
      lb_byte = lb_b;
      lb_valid = 1;
      rx_push(lb_b);
      @(negedge clk);
      lb_valid = 0;
      lb_ready = 1;
      lb_busy = 0;
    end
  end
  task automatic bus(input logic wr, input logic [3:0] a, input logic [31:0] d, input string nm = "rd",
                     input logic inj = 0, input logic [7:0] ib = 0);
    logic [31:0] e;
    HSEL = 1;
    HTRANS = $urandom_range(0, 1) != 0 ? HT_NONSEQ : HT_SEQ;
    HADDR = a;
    HWRITE = wr;
    HSIZE = 3'($urandom);
    @(posedge clk);
    #1;
    HTRANS = HT_IDLE;
    HSEL = 1'($urandom);
    HADDR = 4'($urandom);
    HWRITE = 1'($urandom);
    HWDATA = d;
    if (wr) begin
      case (a)
        4'h0: if (tx_m.size() < D) tx_m.push_back(d[7:0]); else m_drop = 1;
        4'h4: begin
          if (d[4]) m_ovr = 0;
          if (d[5]) m_drop = 0;
        end
        4'h8: m_ctrl = d[1:0];
        default: ;
      endcase
    end else begin
      e = 0;
      if (a == 4'h0 && rx_m.size() != 0) e = {24'h0, rx_m.pop_front()};
      else if (a == 4'h4) e = st_model();
      else if (a == 4'h8) e = {30'h0, m_ctrl};
      rd_exp.push_back(e);
      rd_nm.push_back(nm);
      rd_dp = 1;
    end
    if (inj) begin
      man_byte = ib;
      man_valid = 1;
      rx_push(ib);
    end
    @(posedge clk);
    #1;
    rd_dp = 0;
    man_valid = 0;
  endtask
  task automatic inject(input logic [7:0] b);
    man_byte = b;
    man_valid = 1;
    rx_push(b);
    @(posedge clk);
    #1;
    man_valid = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      HSEL = 1'($urandom);
      HTRANS = $urandom_range(0, 1) != 0 ? HT_IDLE : HT_BUSY;
      HADDR = 4'($urandom);
      @(posedge clk);
      #1;
    end
    HSEL = 0;
    HTRANS = HT_IDLE;
  endtask
  task automatic wait_quiet();
    int n = 0;
    while ((tx_m.size() != 0 || lb_busy) && n < 2000) begin
      idle(1);
      n++;
    end
    chk("tx_drain_timeout", 32'(n < 2000), 1);
    idle(4);
  endtask
  task automatic rst();
    n_rst = 0;
    loop_en = 0;
    man_valid = 0;
    man_ready = 1;
    HSEL = 0;
    HTRANS = HT_IDLE;
    rd_dp = 0;
    tx_m.delete();
    rx_m.delete();
    rd_exp.delete();
    rd_nm.delete();
    m_ovr = 0;
    m_drop = 0;
    m_ctrl = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hrdata", HRDATA, 0);
    chk("rst_uart_in_valid", 32'(uart_in_valid), 0);
    chk("rst_uart_in", 32'(uart_in), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_hreadyout_hresp", {30'h0, HREADYOUT, HRESP}, 32'h2);
    n_rst = 1;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst();
    // reset landing in the cycle the TX strobe is high
    bus(1, 4'h0, 32'h77);
    @(posedge clk);
    #1;
    chk("send_pulse", 32'(uart_in_valid), 1);
    chk("send_byte", 32'(uart_in), 32'h77);
    rst();
    idle(20);
    bus(0, 4'h4, 0, "status_after_rst");
    chk("irq_after_rst", 32'(irq), 0);
    // three bytes looped back
    loop_en = 1;
    bus(1, 4'h0, 32'h41);
    bus(1, 4'h0, 32'h42);
    bus(1, 4'h0, 32'h43);
    wait_quiet();
    for (int i = 0; i < 3; i++) bus(0, 4'h0, 0, "loop3_data");
    bus(0, 4'h4, 0, "loop3_status");
    // TX overflow with the UART held busy
    rst();
    man_ready = 0;
    for (int i = 0; i <= D; i++) bus(1, 4'h0, 32'(i + 8'h60));
    bus(0, 4'h4, 0, "tx_full_drop_status");
    bus(1, 4'h4, 32'h20);
    bus(0, 4'h4, 0, "tx_drop_cleared");
    bus(1, 4'h8, 32'hFFFF_FFFF);
    bus(0, 4'h8, 0, "ctrl_rw");
    bus(1, 4'hC, 32'h5);
    bus(0, 4'hC, 0, "reserved_reads_0");
    bus(1, 4'h8, 32'h0);
    // RX overrun
    rst();
    for (int i = 0; i <= D; i++) inject(8'(i));
    bus(0, 4'h4, 0, "rx_ovr_status");
    for (int i = 0; i < D; i++) bus(0, 4'h0, 0, "rx_ovr_data");
    bus(0, 4'h4, 0, "rx_drained_status");
    bus(1, 4'h4, 32'h10);
    bus(0, 4'h4, 0, "rx_ovr_cleared");
    bus(0, 4'h0, 0, "rx_empty_read");
    // full RX with a pop in the same cycle as the push
    rst();
    for (int i = 0; i < D; i++) inject(8'(i));
    bus(0, 4'h0, 0, "rd_coincide", 1, 8'h10);
    bus(0, 4'h4, 0, "coincide_status");
    for (int i = 0; i < D; i++) bus(0, 4'h0, 0, "coincide_data");
    // irq
    rst();
    bus(1, 4'h8, 32'h1);
    chk("irq_ctrl_only", 32'(irq), 0);
    inject(8'h5A);
    chk("irq_push_cycle", 32'(irq), 0);
    @(posedge clk);
    #1;
    chk("irq_rise", 32'(irq), 1);
    bus(0, 4'h0, 0, "irq_data");
    chk("irq_hold", 32'(irq), 1);
    @(posedge clk);
    #1;
    chk("irq_fall", 32'(irq), 0);
    bus(1, 4'h8, 32'h2);
    chk("irq_tx_pre", 32'(irq), 0);
    @(posedge clk);
    #1;
    chk("irq_tx_empty", 32'(irq), 1);
    // random loopback
    rst();
    loop_en = 1;
    for (int i = 0; i < 100; i++) begin
      int g = 0;
      while (tx_m.size() >= 8 && g < 500) begin
        idle(1);
        g++;
      end
      bus(1, 4'h0, $urandom);
      idle($urandom_range(0, 3));
      if (rx_m.size() > 6 || $urandom_range(0, 2) == 0) bus(0, 4'h0, 0, "rand_data");
    end
    wait_quiet();
    for (int g = 0; rx_m.size() != 0 && g < 200; g++) bus(0, 4'h0, 0, "rand_drain");
    bus(0, 4'h4, 0, "rand_status");
    idle(2);
    chk("rand_pending_reads", 32'(rd_exp.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
